// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the uart_tx_gen2 transmitter and its input FIFO:
//   - tx_state_t : transmitter FSM states (BREAK only when UART_TX_BREAK_EN
//                  is defined)
//   - PAR_EVEN / PAR_ODD : values of the Parity_TYP input
//   - STOP_ONE / STOP_TWO : values of the Stop2 input
//   - clog2()    : ceiling log2, used to size pointers and the level output
//   - parity_bit(): parity bit from the XOR of the payload and parity type
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
`ifdef UART_TX_BREAK_EN
    ,
    BREAK
`endif
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Odd parity is the inverted XOR of the payload.
  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    return data_xor ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous first-word-fall-through FIFO feeding the UART transmitter.
// rdata always shows the oldest word; pop consumes it at the clock edge.
// Pushes while full and pops while empty are ignored.
//
// Ports:
//   Clk    in   system clock
//   Reset  in   asynchronous, active-high reset (empties the FIFO)
//   push   in   write request
//   wdata  in   DATA_WIDTH word to write
//   pop    in   read request
//   rdata  out  oldest word (valid when !empty)
//   full   out  FIFO holds FIFO_DEPTH words
//   empty  out  FIFO holds no words
//   level  out  number of words held, clog2(FIFO_DEPTH)+1 bits
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          full,
  output logic                          empty,
  output logic [clog2(FIFO_DEPTH):0]    level
);

  localparam int AW = clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push_en;
  logic                  pop_en;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and level define
  // which entries are valid, so clearing the data would buy nothing.
  always_ff @(posedge Clk) begin
    if (push_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (pop_en) begin
        rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      // Simultaneous push and pop leaves the level unchanged.
      if (push_en && !pop_en) begin
        level <= level + LW'(1);
      end else if (pop_en && !push_en) begin
        level <= level - LW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_gen2.sv
// ---------------------------------------------------------------------------
// uart_tx_gen2
// Parametrised UART transmitter with an input FIFO, runtime baud prescaler,
// optional even/odd parity and 1 or 2 stop bits. Words are sent LSB-first.
// Frame settings (Parity_EN, Parity_TYP, Stop2, Prescale) are captured when
// a word is popped from the FIFO and hold for that whole frame. A non-empty
// FIFO at the end of STOP starts the next frame with no idle gap.
//
// Optional feature macro: UART_TX_BREAK_EN
//   Adds input Send_Break and state BREAK. From IDLE, Send_Break holds the
//   line low (priority over pending words); on release one bit time of high
//   is driven before returning to IDLE. Requests during a frame wait until
//   the frame is over.
//
// Ports:
//   Clk          in   system clock
//   Reset        in   asynchronous, active-high reset
//   P_Data       in   DATA_WIDTH word to transmit
//   D_Valid      in   P_Data valid
//   D_Ready      out  FIFO can accept (transfer on D_Valid & D_Ready)
//   Parity_EN    in   1 = parity bit after data
//   Parity_TYP   in   0 = even, 1 = odd
//   Stop2        in   1 = two stop bits, 0 = one
//   Prescale     in   each serial bit lasts Prescale+1 Clk cycles
//   Send_Break   in   (UART_TX_BREAK_EN only) request a line break
//   busy         out  FIFO non-empty or frame in progress (registered)
//   Serial_Data  out  TX line, idle high (registered)
//   Fifo_Level   out  words held in the FIFO
// ---------------------------------------------------------------------------
module uart_tx_gen2
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [DATA_WIDTH-1:0]         P_Data,
  input  logic                          D_Valid,
  output logic                          D_Ready,
  input  logic                          Parity_EN,
  input  logic                          Parity_TYP,
  input  logic                          Stop2,
  input  logic [PRESCALE_W-1:0]         Prescale,
`ifdef UART_TX_BREAK_EN
  input  logic                          Send_Break,
`endif
  output logic                          busy,
  output logic                          Serial_Data,
  output logic [clog2(FIFO_DEPTH):0]    Fifo_Level
);

  localparam int CNT_W = (clog2(DATA_WIDTH) < 1) ? 1 : clog2(DATA_WIDTH);

  tx_state_t             state;
  logic [PRESCALE_W-1:0] bit_tmr;
  logic [PRESCALE_W-1:0] prescale_l;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_bit;
  logic                  par_en_l;
  logic                  stop2_l;
  logic                  stop_cnt;

  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  brk_req;
  logic                  tmr_done;
  logic                  last_stop;

`ifdef UART_TX_BREAK_EN
  logic                  brk_rel;
  assign brk_req = Send_Break;
`else
  assign brk_req = 1'b0;
`endif

  assign D_Ready   = !fifo_full;
  assign tmr_done  = (bit_tmr == prescale_l);
  assign last_stop = (stop2_l == STOP_ONE) || stop_cnt;

  // The FSM takes a word either from IDLE or at the very end of the last
  // stop bit (back-to-back frames). A pending break blocks both.
  assign fifo_pop = !fifo_empty && !brk_req &&
                    ((state == IDLE) ||
                     ((state == STOP) && tmr_done && last_stop));

  uart_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (D_Valid),
    .wdata (P_Data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (Fifo_Level)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      Serial_Data <= 1'b1;
      busy        <= 1'b0;
      bit_tmr     <= '0;
      prescale_l  <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      par_bit     <= 1'b0;
      par_en_l    <= 1'b0;
      stop2_l     <= STOP_ONE;
      stop_cnt    <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_rel     <= 1'b0;
`endif
    end else begin
      busy <= (state != IDLE) || (Fifo_Level != '0);

      // Bit timer free-runs 0..prescale_l in every active state.
      if (state != IDLE) begin
        bit_tmr <= tmr_done ? '0 : bit_tmr + PRESCALE_W'(1);
      end

      case (state)
        IDLE: begin
          Serial_Data <= 1'b1;
`ifdef UART_TX_BREAK_EN
          if (brk_req) begin
            state       <= BREAK;
            Serial_Data <= 1'b0;
            bit_tmr     <= '0;
            prescale_l  <= Prescale;
            brk_rel     <= 1'b0;
          end
`endif
        end

        START: begin
          if (tmr_done) begin
            state       <= DATA;
            bit_cnt     <= '0;
            Serial_Data <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
          end
        end

        DATA: begin
          if (tmr_done) begin
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              if (par_en_l) begin
                state       <= PARITY;
                Serial_Data <= par_bit;
              end else begin
                state       <= STOP;
                Serial_Data <= 1'b1;
                stop_cnt    <= 1'b0;
              end
            end else begin
              bit_cnt     <= bit_cnt + CNT_W'(1);
              Serial_Data <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
            end
          end
        end

        PARITY: begin
          if (tmr_done) begin
            state       <= STOP;
            Serial_Data <= 1'b1;
            stop_cnt    <= 1'b0;
          end
        end

        STOP: begin
          if (tmr_done) begin
            if (!last_stop) begin
              stop_cnt <= 1'b1;
            end else begin
              state       <= IDLE;
              Serial_Data <= 1'b1;
            end
          end
        end

`ifdef UART_TX_BREAK_EN
        BREAK: begin
          if (!brk_rel) begin
            // Hold the line low with the timer parked until release.
            bit_tmr     <= '0;
            Serial_Data <= 1'b0;
            if (!brk_req) begin
              brk_rel     <= 1'b1;
              Serial_Data <= 1'b1;
            end
          end else if (tmr_done) begin
            state   <= IDLE;
            brk_rel <= 1'b0;
          end
        end
`endif

        default: begin
          state       <= IDLE;
          Serial_Data <= 1'b1;
        end
      endcase

      // A pop overrides the transition chosen above: load the next word,
      // capture its frame settings and start driving the start bit.
      if (fifo_pop) begin
        state       <= START;
        Serial_Data <= 1'b0;
        bit_tmr     <= '0;
        shift_reg   <= fifo_rdata;
        par_bit     <= parity_bit(^fifo_rdata, Parity_TYP);
        par_en_l    <= Parity_EN;
        stop2_l     <= Stop2;
        prescale_l  <= Prescale;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_gen2.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_gen2
// Self-checking bench for uart_tx_gen2 (default build). Each accepted word is
// queued with the frame settings it was sent with; a line monitor rebuilds
// the expected bit sequence and compares the line every Clk of every bit.
// ---------------------------------------------------------------------------
module tb_uart_tx_gen2;

  localparam int DW = 8;
  localparam int FD = 4;
  localparam int PW = 8;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [DW-1:0] P_Data;
  logic          D_Valid;
  logic          D_Ready;
  logic          Parity_EN;
  logic          Parity_TYP;
  logic          Stop2;
  logic [PW-1:0] Prescale;
  logic          busy;
  logic          Serial_Data;
  logic [2:0]    Fifo_Level;

  typedef struct {
    logic [DW-1:0] data;
    bit            par_en;
    bit            par_typ;
    bit            stop2;
    int            pre;
    bit            contig;
  } frame_t;

  frame_t sb[$];
  int     n_cmp    = 0;
  int     n_err    = 0;
  bit     mon_en   = 1'b0;
  bit     mon_busy = 1'b0;

  always #5 Clk = ~Clk;

  uart_tx_gen2 #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD),
    .PRESCALE_W (PW)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .P_Data      (P_Data),
    .D_Valid     (D_Valid),
    .D_Ready     (D_Ready),
    .Parity_EN   (Parity_EN),
    .Parity_TYP  (Parity_TYP),
    .Stop2       (Stop2),
    .Prescale    (Prescale),
    .busy        (busy),
    .Serial_Data (Serial_Data),
    .Fifo_Level  (Fifo_Level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one word with its frame settings; waits (bounded) for D_Ready.
  task automatic push_word(input logic [DW-1:0] d, input bit pe, input bit pt,
                           input bit s2, input int pre, input bit contig,
                           input bit to_sb, output int waited);
    frame_t f;
    @(negedge Clk);
    P_Data     = d;
    Parity_EN  = pe;
    Parity_TYP = pt;
    Stop2      = s2;
    Prescale   = PW'(pre);
    D_Valid    = 1'b1;
    waited     = 0;
    while (!D_Ready && waited < 2000) begin
      @(negedge Clk);
      waited++;
    end
    if (!D_Ready) begin
      check("push_timeout", {31'd0, D_Ready}, 1);
      D_Valid = 1'b0;
    end else begin
      @(posedge Clk);
      f.data    = d;
      f.par_en  = pe;
      f.par_typ = pt;
      f.stop2   = s2;
      f.pre     = pre;
      f.contig  = contig;
      if (to_sb) sb.push_back(f);
      #1 D_Valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < 5000) begin
      @(negedge Clk);
      n++;
    end
    check({tag, "_drained"}, {31'd0, (sb.size() == 0 && !mon_busy)}, 1);
    repeat (4) @(negedge Clk);
    check({tag, "_busy_low"}, {31'd0, busy}, 0);
    check({tag, "_line_idle"}, {31'd0, Serial_Data}, 1);
    check({tag, "_level_zero"}, {29'd0, Fifo_Level}, 0);
  endtask

  // Line monitor: every sample of every bit of every frame is compared.
  initial begin : monitor
    frame_t f;
    logic   exp_bits [16];
    int     nb;
    bit     contig_next;
    contig_next = 1'b0;
    forever begin
      @(negedge Clk);
      if (!mon_en) begin
        contig_next = 1'b0;
      end else if (contig_next || Serial_Data == 1'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_start", {31'd0, Serial_Data}, 1);
          contig_next = 1'b0;
        end else begin
          mon_busy = 1'b1;
          f = sb.pop_front();
          exp_bits[0] = 1'b0;
          for (int i = 0; i < DW; i++) exp_bits[1 + i] = f.data[i];
          nb = 1 + DW;
          if (f.par_en) begin
            exp_bits[nb] = (^f.data) ^ f.par_typ;
            nb++;
          end
          exp_bits[nb] = 1'b1;
          nb++;
          if (f.stop2) begin
            exp_bits[nb] = 1'b1;
            nb++;
          end
          for (int b = 0; b < nb; b++) begin
            for (int s = 0; s <= f.pre; s++) begin
              if (!(b == 0 && s == 0)) @(negedge Clk);
              check($sformatf("w%02h_bit%0d_s%0d", f.data, b, s),
                    {31'd0, Serial_Data}, {31'd0, exp_bits[b]});
            end
          end
          contig_next = (sb.size() > 0) && sb[0].contig;
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          w;
    logic [DW-1:0] burst [5];
    burst = '{8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h99};

    Reset      = 1'b1;
    P_Data     = '0;
    D_Valid    = 1'b0;
    Parity_EN  = 1'b0;
    Parity_TYP = 1'b0;
    Stop2      = 1'b0;
    Prescale   = '0;

    // Reset values, during and after reset.
    repeat (3) @(negedge Clk);
    check("rst_line", {31'd0, Serial_Data}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ready", {31'd0, D_Ready}, 1);
    check("rst_level", {29'd0, Fifo_Level}, 0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    check("idle_line", {31'd0, Serial_Data}, 1);
    check("idle_busy", {31'd0, busy}, 0);
    mon_en = 1'b1;

    // Single word, Prescale=0: pop one edge after push, line low after it.
    push_word(8'hA5, 0, 0, 0, 0, 0, 1, w);
    check("a5_line_at_push", {31'd0, Serial_Data}, 1);
    check("a5_level_at_push", {29'd0, Fifo_Level}, 1);
    @(posedge Clk);
    #1;
    check("a5_line_after_pop", {31'd0, Serial_Data}, 0);
    check("a5_level_after_pop", {29'd0, Fifo_Level}, 0);
    wait_done("a5");

    // Odd parity, 4 Clk per bit: parity of 8'h07 must be 0.
    push_word(8'h07, 1, 1, 0, 3, 0, 1, w);
    wait_done("par07");

    // Burst: one running frame plus five more words into a 4-deep FIFO.
    push_word(8'h3C, 0, 0, 0, 1, 0, 1, w);
    for (int k = 0; k < 5; k++) begin
      push_word(burst[k], 0, 0, 0, 1, 1, 1, w);
      if (k == 3) begin
        check("burst_full_ready", {31'd0, D_Ready}, 0);
        check("burst_full_level", {29'd0, Fifo_Level}, 4);
        check("burst_busy", {31'd0, busy}, 1);
      end
      if (k == 4) check("burst_fifth_waited", {31'd0, (w > 0)}, 1);
    end
    wait_done("burst");

    // Two stop bits, Prescale=1; Prescale changed mid-frame is ignored.
    push_word(8'h96, 1, 0, 1, 1, 0, 1, w);
    repeat (3) @(negedge Clk);
    Prescale = PW'(5);
    wait_done("stop2");
    Prescale = '0;

    // Asynchronous reset in the middle of DATA of 8'h00 with words queued.
    mon_en = 1'b0;
    push_word(8'h00, 0, 0, 0, 3, 0, 0, w);
    push_word(8'hAA, 0, 0, 0, 3, 0, 0, w);
    push_word(8'h55, 0, 0, 0, 3, 0, 0, w);
    repeat (6) @(negedge Clk);
    check("pre_rst_line_low", {31'd0, Serial_Data}, 0);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_line", {31'd0, Serial_Data}, 1);
    check("async_rst_busy", {31'd0, busy}, 0);
    check("async_rst_level", {29'd0, Fifo_Level}, 0);
    check("async_rst_ready", {31'd0, D_Ready}, 1);
    repeat (2) @(negedge Clk);
    Reset  = 1'b0;
    mon_en = 1'b1;
    repeat (60) @(negedge Clk);
    check("post_rst_line", {31'd0, Serial_Data}, 1);
    check("post_rst_busy", {31'd0, busy}, 0);
    check("post_rst_level", {29'd0, Fifo_Level}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
